// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Carry entering the top bit of a nibble, recovered from that bit's sum.
  function automatic logic msb_carry_in(input logic a_bit, input logic b_bit, input logic s_bit);
    return a_bit ^ b_bit ^ s_bit;
  endfunction

endpackage

// File: rtl/ripple_4.sv
// 4-bit ripple-carry adder used as the per-cycle datapath stage.
module ripple_4
  import nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] S,
  output logic                c_out
);

  logic [NIBBLE_W:0] carry_s;

  assign carry_s[0] = c_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign S[i]         = A[i] ^ B[i] ^ carry_s[i];
    assign carry_s[i+1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
  end

  assign c_out = carry_s[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder/subtractor that reuses one 4-bit stage, one nibble per clock, LSB first.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             c_out
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  import nibble_serial_pkg::*;

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e                state_r, state_next_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [WIDTH-1:0]      a_r, b_r, s_r;
  logic                  carry_r, c_out_r;
  logic                  in_ready_r, out_valid_r;
  logic                  accept_s, last_s;
  logic [NIBBLE_W-1:0]   stage_sum_s;
  logic                  stage_co_s;

  assign accept_s = in_valid & in_ready_r;
  assign last_s   = (cnt_r == CNT_W'(NIBBLES - 1));

  ripple_4 u_stage (
    .A     (a_r[NIBBLE_W-1:0]),
    .B     (b_r[NIBBLE_W-1:0]),
    .c_in  (carry_r),
    .S     (stage_sum_s),
    .c_out (stage_co_s)
  );

  // Next-state decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_RUN;
        else          state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_next_s = ST_DONE;
        else        state_next_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) state_next_s = ST_IDLE;
        else           state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register; handshake outputs are decoded from the next state so they leave flops.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture, nibble shifting, carry chaining and result capture.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      a_r     <= A;
      b_r     <= B ^ {WIDTH{sub}};
      carry_r <= sub ? 1'b1 : c_in;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      // Sum nibbles enter from the top so the LSB nibble ends up at the bottom.
      s_r     <= {stage_sum_s, s_r[WIDTH-1:NIBBLE_W]};
      a_r     <= {{NIBBLE_W{1'b0}}, a_r[WIDTH-1:NIBBLE_W]};
      b_r     <= {{NIBBLE_W{1'b0}}, b_r[WIDTH-1:NIBBLE_W]};
      carry_r <= stage_co_s;
      cnt_r   <= cnt_r + CNT_W'(1'b1);
      if (last_s) c_out_r <= stage_co_s;
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // Signed overflow: carry into the MSB differs from carry out of it on the final nibble.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ovf_r <= 1'b0;
    end else if ((state_r == ST_RUN) && last_s && !accept_s) begin
      ovf_r <= msb_carry_in(a_r[NIBBLE_W-1], b_r[NIBBLE_W-1], stage_sum_s[NIBBLE_W-1]) ^ stage_co_s;
    end
  end

  assign ovf = ovf_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign S         = s_r;
  assign c_out     = c_out_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, S;
  logic        c_in, sub, c_out;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .c_out     (c_out)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present operands, wait (bounded) for in_ready, then return just after the accept edge.
  task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    int n;
    n = 0;
    A = a; B = b; c_in = ci; sub = sb; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (out_valid !== 1'b1 && cycles < 40);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task test_reset();
    Reset_n = 1'b0;
    repeat (3) step();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b required=0/0", in_ready, out_valid);
    end
    total++;
    if (S !== 16'h0000 || c_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_data S=%h c_out=%b required=0000/0", S, c_out);
    end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b required=0", ovf); end
`endif
    Reset_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release in_ready=%b out_valid=%b required=1/0", in_ready, out_valid);
    end
  endtask

  task test_add();
    int cyc;
    accept_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    A = 16'h1111; B = 16'h2222; c_in = 1'b1; sub = 1'b1;
    wait_done(cyc);
    total++;
    if (cyc !== 4) begin bad++; $display("FAIL carry_chain_latency got=%0d required=4", cyc); end
    total++;
    if (S !== 16'h0000 || c_out !== 1'b1) begin
      bad++;
      $display("FAIL carry_chain S=%h c_out=%b required=0000/1", S, c_out);
    end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL carry_chain_ovf got=%b required=0", ovf); end
`endif
    pop();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || S !== 16'h0000) begin
      bad++;
      $display("FAIL pop out_valid=%b in_ready=%b S=%h required=0/1/0000", out_valid, in_ready, S);
    end
    accept_op(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc !== 4 || S !== 16'h5556 || c_out !== 1'b0) begin
      bad++;
      $display("FAIL simple_add cyc=%0d S=%h c_out=%b required=4/5556/0", cyc, S, c_out);
    end
    pop();
  endtask

  task test_sub();
    int cyc;
    accept_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done(cyc);
    total++;
    if (S !== 16'hFFFE || c_out !== 1'b0) begin
      bad++;
      $display("FAIL sub_borrow S=%h c_out=%b required=fffe/0", S, c_out);
    end
    pop();
    accept_op(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_done(cyc);
    total++;
    if (S !== 16'h0002 || c_out !== 1'b1) begin
      bad++;
      $display("FAIL sub_noborrow S=%h c_out=%b required=0002/1", S, c_out);
    end
    pop();
  endtask

  task test_overflow();
    int cyc;
    accept_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc);
    total++;
    if (S !== 16'h8000 || c_out !== 1'b0) begin
      bad++;
      $display("FAIL ovf_add S=%h c_out=%b required=8000/0", S, c_out);
    end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_add_flag got=%b required=1", ovf); end
`endif
    pop();
    accept_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(cyc);
    total++;
    if (S !== 16'h7FFF || c_out !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sub S=%h c_out=%b required=7fff/1", S, c_out);
    end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sub_flag got=%b required=1", ovf); end
`endif
    pop();
  endtask

  task test_backpressure();
    int cyc;
    accept_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b0);
    A = 16'h0001; B = 16'h0002; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    wait_done(cyc);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || S !== 16'hFFFF || c_out !== 1'b0) begin
        bad++;
        $display("FAIL stall[%0d] out_valid=%b in_ready=%b S=%h c_out=%b required=1/0/ffff/0",
                 i, out_valid, in_ready, S, c_out);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release out_valid=%b in_ready=%b required=0/1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL stalled_accept in_ready=%b required=0", in_ready); end
    wait_done(cyc);
    total++;
    if (cyc !== 4 || S !== 16'h0004 || c_out !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back cyc=%0d S=%h c_out=%b required=4/0004/0", cyc, S, c_out);
    end
    pop();
  endtask

  task test_reset_mid();
    int cyc;
    int seen;
    accept_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    step();
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    total++;
    if (S !== 16'h0000 || out_valid !== 1'b0 || c_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid S=%h out_valid=%b c_out=%b required=0000/0/0", S, out_valid, c_out);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_discard valid_cycles=%0d in_ready=%b required=0/1", seen, in_ready);
    end
    accept_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc !== 4 || S !== 16'h1000 || c_out !== 1'b0) begin
      bad++;
      $display("FAIL after_reset cyc=%0d S=%h c_out=%b required=4/1000/0", cyc, S, c_out);
    end
    pop();
  endtask

  initial begin
    Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 16'h0000; B = 16'h0000; c_in = 1'b0; sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
